// File: rtl/inst_fetch_pkg.sv
// Shared constants, entry type and FSM encoding for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'b00,
    RUN        = 2'b01,
    DRAIN      = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fq_entry_t;

  // Instructions are word aligned; low address bits are simply dropped.
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_fetch_queue.sv
// Synchronous FIFO of {pc, inst} entries with flush. Pointers carry one extra
// wrap bit so full and empty are told apart by comparing the MSBs.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  fq_entry_t   mem_q [DEPTH];
  logic        empty;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Entry storage; unreset, since nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, run/drain FSM, redirect handling, fetch
// counter and a small queue decoupling memory from the consumer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_count
);

  fetch_state_e             state_q;
  fetch_state_e             state_d;
  logic [31:0]              pc_q;
  logic [31:0]              fetch_count_q;
  logic                     fq_full;
  logic [$clog2(FQ_DEPTH):0] fq_count;
  fq_entry_t                fq_wdata;
  fq_entry_t                fq_rdata;
  logic                     pop_req;
  logic                     push_req;

  assign inst_valid  = (fq_count != '0);
  assign inst        = inst_valid ? fq_rdata.inst : '0;
  assign inst_pc     = inst_valid ? fq_rdata.pc   : '0;
  assign imem_addr   = pc_q;
  assign fetch_count = fetch_count_q;
  assign fq_wdata    = '{pc: pc_q, inst: imem_inst};

  // Redirect takes the cycle: no pop, no push.
  assign pop_req  = inst_valid & inst_ready & ~redirect_valid;
  // Fetching happens in any cycle that ends in RUN, so the cycle leaving
  // RESET_WAIT or DRAIN already fetches.
  assign push_req = (state_d == RUN) & ~redirect_valid & (~fq_full | pop_req);

  // Next-state logic; en alone steers the FSM, a redirect freezes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_WAIT: if (en)  state_d = RUN;
      RUN:        if (!en) state_d = DRAIN;
      DRAIN:      if (en)  state_d = RUN;
      default:    state_d = RESET_WAIT;
    endcase
    if (redirect_valid) state_d = state_q;
  end

  // State, PC and fetch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RESET_WAIT;
      pc_q          <= PC_RESET;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
      end else if (push_req) begin
        pc_q          <= pc_q + PC_STEP;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (fq_wdata),
    .rdata (fq_rdata),
    .full  (fq_full),
    .count (fq_count)
  );

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of 2, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  fetch enable; 0 = no new fetches, queue still drains.
REQ-006 imem_addr  output  32  byte address driven to instruction memory; equals PC register.
REQ-007 imem_inst  input  32  big-endian instruction word; combinational, valid in the same cycle as imem_addr.
REQ-008 redirect_valid  input  1  one-cycle request to change PC (branch/jump).
REQ-009 redirect_pc  input  32  redirect target; sampled when redirect_valid=1.
REQ-010 inst_valid  output  1  queue head holds a valid instruction.
REQ-011 inst_ready  input  1  consumer accepts head when inst_valid & inst_ready.
REQ-012 inst  output  32  instruction at queue head.
REQ-013 inst_pc  output  32  PC of instruction at queue head.
REQ-014 fetch_count  output  32  number of words pushed since reset; wraps modulo 2^32.

Function
REQ-015 Push condition: en=1, redirect_valid=0, and (queue not full or pop this cycle).
REQ-016 On push: write {PC, imem_inst} at queue tail; PC <= PC + 4 modulo 2^32; fetch_count += 1.
REQ-017 Pop: occurs when inst_valid & inst_ready; head advances one entry.
REQ-018 Simultaneous push and pop on a full queue: both occur; occupancy stays FQ_DEPTH.
REQ-019 Simultaneous push and pop on an empty queue: the pop is void (inst_valid=0); the push alone occurs.
REQ-020 inst_valid = occupancy != 0; inst/inst_pc come from registered queue storage, never directly from imem_inst.
REQ-021 Latency: a word fetched at edge N appears on inst/inst_valid after edge N (one cycle).
REQ-022 Redirect (highest priority): queue flushed to empty, PC <= {redirect_pc[31:2], 2'b00}, no push and no pop that cycle, fetch_count unchanged.
REQ-023 Misaligned redirect_pc: bits [1:0] silently forced to zero; no error output.
REQ-024 FSM states: RESET_WAIT, RUN, DRAIN.
REQ-025 RESET_WAIT: entered on rst; exits to RUN on the first cycle with en=1, otherwise stays.
REQ-026 RUN: pushes per REQ-015; en=0 transitions to DRAIN.
REQ-027 DRAIN: no pushes; pops continue; en=1 returns to RUN; redirect in any state applies REQ-022 without changing state.
REQ-028 Queue pointers: log2(FQ_DEPTH)+1 bits; full/empty derived from MSB comparison; pointers wrap naturally.
REQ-029 PC wrap from 32'hFFFF_FFFC to 32'h0000_0000 is legal and silent.

Reset
REQ-030 On rst=1 at a clock edge: PC=PC_RESET, queue empty, fetch_count=0, state=RESET_WAIT.
REQ-031 During reset: inst_valid=0, imem_addr=PC_RESET, inst=0, inst_pc=0.
REQ-032 Reset mid-operation overrides push, pop, and redirect in the same cycle; in-flight queue contents are discarded.

Structure
REQ-033 Shared package constants.vh: INST_WIDTH=32, ADDR_WIDTH=32, PC_STEP=4, FSM state encodings (2-bit).
REQ-034 One sub-module, fetch_queue: parameterised synchronous FIFO of {pc,inst} entries with push/pop/flush, full/empty, count.
REQ-035 inst_fetch holds the PC register, the FSM, the redirect logic, fetch_count, and one fetch_queue instance.

Verification
REQ-036 Reset, en=1, inst_ready=1, memory words 0x11111111/0x22222222/0x33333333 at 0/4/8 -> inst_pc 0,4,8 on consecutive cycles from cycle 1; fetch_count=3 after three edges.
REQ-037 inst_ready=0 for 10 cycles with en=1 -> exactly FQ_DEPTH=4 pushes, imem_addr holds 0x10, inst_valid stays 1, head inst_pc=0.
REQ-038 Full queue, redirect_valid=1 with redirect_pc=0x00000103 -> next cycle inst_valid=0, imem_addr=0x100; following cycle head inst_pc=0x100.
REQ-039 Full queue with inst_ready=1 and en=1 -> one push and one pop every cycle; occupancy stays 4; inst_pc advances by 4 per cycle.
REQ-040 PC_RESET=32'hFFFFFFF8 -> fetched PCs FFFFFFF8, FFFFFFFC, 00000000; en=0 -> state DRAIN, queue empties, fetch_count frozen at 3.
REQ-041 Assert rst for one cycle while queue holds 3 entries and redirect_valid=1 -> next cycle inst_valid=0, imem_addr=PC_RESET, fetch_count=0.
